// File: rtl/alu_program_sequencer_if.sv
// alu_program_sequencer_if: program-load, start and ALU/status bus between host and sequencer
interface alu_program_sequencer_if;
    logic       load;
    logic [2:0] load_addr;
    logic [2:0] load_fun;
    logic [3:0] load_a;
    logic       load_halt;
    logic       start;
    logic [7:0] alu_result;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_fun;
    logic [7:0] acc;
    logic [2:0] pc;
    logic       busy;
    logic       done;
    modport master (
        output load, load_addr, load_fun, load_a, load_halt, start, alu_result,
        input  alu_a, alu_b, alu_fun, acc, pc, busy, done
    );
    modport slave (
        input  load, load_addr, load_fun, load_a, load_halt, start, alu_result,
        output alu_a, alu_b, alu_fun, acc, pc, busy, done
    );
endinterface

// File: rtl/alu_program_sequencer.sv
// alu_program_sequencer: steps a loaded program through an external ALU, two cycles per entry, accumulating results
module alu_program_sequencer #(
    parameter int PROG_DEPTH = 8
) (
    input logic                    clock,
    input logic                    reset,
    alu_program_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
    state_t     state, state_nx;
    logic [7:0] mem [PROG_DEPTH];
    logic [7:0] entry, acc;
    logic [2:0] pc;
    logic       ready, last;
    // entry layout: {fun[2:0], a[3:0], halt}
    assign entry = mem[pc];
    assign ready = state == IDLE || state == DONE;
    assign last  = entry[0] || pc == 3'(PROG_DEPTH - 1);
    always_comb begin
        state_nx    = state;
        state_nx    = state == ISSUE ? CAPTURE : state == CAPTURE ? (last ? DONE : ISSUE) : bus.start ? ISSUE : state;
        bus.busy    = !ready;
        bus.done    = state == DONE;
        bus.alu_a   = ready ? 4'd0 : entry[4:1];
        bus.alu_fun = ready ? 3'd0 : entry[7:5];
        bus.alu_b   = acc[3:0];
        bus.acc     = acc;
        bus.pc      = pc;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            pc    <= '0;
            acc   <= '0;
            for (int i = 0; i < PROG_DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_nx;
            if (ready && bus.load) mem[bus.load_addr] <= {bus.load_fun, bus.load_a, bus.load_halt};
            if (ready && bus.start) pc <= '0;
            else if (state == CAPTURE && !last) pc <= pc + 3'd1;
            if (state == CAPTURE) acc <= bus.alu_result;
        end
    end
endmodule

// File: tb/tb_alu_program_sequencer.sv
// tb_alu_program_sequencer: program-level reference model plus directed scenarios with literal expectations
module tb_alu_program_sequencer;
    logic clock = 0;
    logic reset = 1;
    int   n_pass = 0;
    int   n_total = 0;
    alu_program_sequencer_if bus ();
    alu_program_sequencer dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    // external ALU: 0 max(a,b)|(a==b), 1 add, 2 b-a, 3 and, 4 xor, 5 b<<a, 6 b>>a, 7 a*b
    function automatic logic [7:0] alu(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
        case (f)
            3'd0:    return ((a > b) ? 8'(a) : 8'(b)) | 8'(a == b);
            3'd1:    return 8'(a) + 8'(b);
            3'd2:    return 8'(b) - 8'(a);
            3'd3:    return 8'(a & b);
            3'd4:    return 8'(a ^ b);
            3'd5:    return 8'(b) << a;
            3'd6:    return 8'(b) >> a;
            default: return 8'(a) * 8'(b);
        endcase
    endfunction
    always_comb bus.alu_result = alu(bus.alu_fun, bus.alu_a, bus.alu_b);
    typedef struct packed {
        logic [7:0] acc;
        logic [2:0] pc;
        logic       busy;
        logic       done;
        logic [3:0] a;
        logic [2:0] fun;
    } obs_t;
    obs_t       q[$];
    obs_t       exp_o;
    logic [7:0] m_mem [8];
    logic [7:0] m_acc;
    logic [2:0] m_pc;
    logic       m_done;
    bit         running = 0;
    bit         model_ok = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask
    // model: a start expands the program into its per-cycle expected trace
    initial forever begin
        @(posedge clock);
        if (reset) begin
            q.delete();
            m_mem    = '{default: 8'h00};
            m_acc    = 0;
            m_pc     = 0;
            m_done   = 0;
            running  = 0;
            model_ok = 1;
        end else if (!running) begin
            if (bus.load) m_mem[bus.load_addr] = {bus.load_fun, bus.load_a, bus.load_halt};
            if (bus.start) begin
                for (int i = 0; i < 8; i++) begin
                    obs_t o;
                    o = '{acc: m_acc, pc: 3'(i), busy: 1'b1, done: 1'b0, a: m_mem[i][4:1], fun: m_mem[i][7:5]};
                    q.push_back(o);
                    q.push_back(o);
                    m_acc  = alu(o.fun, o.a, m_acc[3:0]);
                    m_pc   = 3'(i);
                    m_done = 1;
                    if (m_mem[i][0]) break;
                end
            end
        end
        if (q.size() > 0) begin
            exp_o   = q.pop_front();
            running = 1;
        end else begin
            exp_o   = '{acc: m_acc, pc: m_pc, busy: 1'b0, done: m_done, a: 4'd0, fun: 3'd0};
            running = 0;
        end
    end
    initial forever begin
        @(negedge clock);
        if (model_ok) begin
            chk("acc", bus.acc, exp_o.acc);
            chk("pc", bus.pc, exp_o.pc);
            chk("busy", bus.busy, exp_o.busy);
            chk("done", bus.done, exp_o.done);
            chk("alu_a", bus.alu_a, exp_o.a);
            chk("alu_fun", bus.alu_fun, exp_o.fun);
            chk("alu_b", bus.alu_b, exp_o.acc[3:0]);
        end
    end
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask
    task automatic load_entry(input logic [2:0] addr, input logic [2:0] f, input logic [3:0] a, input logic h);
        bus.load      = 1;
        bus.load_addr = addr;
        bus.load_fun  = f;
        bus.load_a    = a;
        bus.load_halt = h;
        cyc();
        bus.load = 0;
    endtask
    task automatic pulse_start();
        bus.start = 1;
        cyc();
        bus.start = 0;
    endtask
    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!bus.done && n < max) begin
            cyc();
            n++;
        end
        chk("wait_done", bus.done, 1);
    endtask
    initial begin
        int n;
        bus.load = 0; bus.load_addr = 0; bus.load_fun = 0; bus.load_a = 0; bus.load_halt = 0; bus.start = 0;
        cyc();
        cyc();
        reset = 0;
        chk("rst_acc", bus.acc, 8'h00);
        chk("rst_pc", bus.pc, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_fun", bus.alu_fun, 0);
        load_entry(0, 3'b001, 4'd3, 0);
        load_entry(1, 3'b111, 4'd2, 1);
        pulse_start();
        cyc();
        cyc();
        chk("p1_acc_e2", bus.acc, 8'h03);
        chk("p1_model_e2", exp_o.acc, 8'h03);
        cyc();
        cyc();
        chk("p1_acc_e4", bus.acc, 8'h06);
        chk("p1_done", bus.done, 1);
        chk("p1_pc", bus.pc, 1);
        chk("p1_model_done", exp_o.done, 1);
        for (int i = 0; i < 8; i++) load_entry(3'(i), 3'b000, 4'd5, 0);
        pulse_start();
        wait_done(40, n);
        chk("p2_cycles", n, 16);
        chk("p2_acc", bus.acc, 8'h06);
        chk("p2_pc", bus.pc, 7);
        chk("p2_model_pc", exp_o.pc, 7);
        load_entry(0, 3'b101, 4'd1, 1);
        pulse_start();
        chk("p3_alu_b", bus.alu_b, 6);
        cyc();
        cyc();
        chk("p3_acc_shl", bus.acc, 8'h0C);
        bus.start = 1;
        load_entry(0, 3'b110, 4'd2, 1);
        bus.start = 0;
        wait_done(10, n);
        chk("p3_acc_shr", bus.acc, 8'h03);
        chk("p3_model_shr", exp_o.acc, 8'h03);
        load_entry(0, 3'b001, 4'd1, 0);
        load_entry(1, 3'b001, 4'd2, 0);
        load_entry(2, 3'b111, 4'd3, 1);
        pulse_start();
        cyc();
        bus.start = 1;
        load_entry(0, 3'b011, 4'hF, 1);
        bus.start = 0;
        wait_done(20, n);
        chk("p4_acc", bus.acc, 8'h12);
        chk("p4_pc", bus.pc, 2);
        pulse_start();
        chk("p4_mem0_a", bus.alu_a, 1);
        chk("p4_mem0_fun", bus.alu_fun, 3'b001);
        wait_done(20, n);
        chk("p4_rerun_acc", bus.acc, 8'h0F);
        pulse_start();
        cyc();
        cyc();
        cyc();
        chk("p5_in_capture_pc", bus.pc, 1);
        reset = 1;
        cyc();
        reset = 0;
        chk("p5_rst_acc", bus.acc, 8'h00);
        chk("p5_rst_done", bus.done, 0);
        chk("p5_rst_busy", bus.busy, 0);
        pulse_start();
        wait_done(40, n);
        chk("p5_cycles", n, 16);
        chk("p5_acc", bus.acc, 8'h01);
        chk("p5_pc", bus.pc, 7);
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_program_sequencer.md
ALU_PROGRAM_SEQUENCER -- requirements
Module: alu_program_sequencer

Interface
REQ-001 Parameter PROG_DEPTH, default 8, number of program entries; fixed at 8 in this revision (3-bit address).
REQ-002 clock  input  1  sole clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-004 load  input  1  write strobe for one program entry.
REQ-005 load_addr  input  3  entry index to write.
REQ-006 load_fun  input  3  ALU function code for the entry.
REQ-007 load_a  input  4  operand A for the entry.
REQ-008 load_halt  input  1  entry is the last one to execute.
REQ-009 start  input  1  begin program execution from entry 0.
REQ-010 alu_result  input  8  combinational result returned by the downstream ALU.
REQ-011 alu_a  output  4  operand A driven to the ALU.
REQ-012 alu_b  output  4  operand B driven to the ALU, always acc[3:0].
REQ-013 alu_fun  output  3  function select driven to the ALU.
REQ-014 acc  output  8  accumulator (captured ALU results).
REQ-015 pc  output  3  index of the entry currently executing.
REQ-016 busy  output  1  high in ISSUE and CAPTURE.
REQ-017 done  output  1  high in DONE.

Function
REQ-018 Program memory: 8 entries of {fun[2:0], a[3:0], halt}, registered, write-only via load, readable internally.
REQ-019 FSM states: IDLE, ISSUE, CAPTURE, DONE; exactly one state active.
REQ-020 IDLE: start=1 -> ISSUE with pc<=0; otherwise stay.
REQ-021 ISSUE: alu_a=mem[pc].a, alu_fun=mem[pc].fun; unconditionally -> CAPTURE next cycle (one settle cycle).
REQ-022 CAPTURE: alu_a/alu_fun held as in ISSUE; on the edge leaving CAPTURE, acc<=alu_result.
REQ-023 CAPTURE exit: if mem[pc].halt=1 or pc=7 -> DONE, pc held; else pc<=pc+1 -> ISSUE.
REQ-024 pc never wraps; entry 7 is always terminal regardless of its halt bit.
REQ-025 Latency: N executed entries take 2N cycles from the start-sampling edge to done=1; acc updates every second edge.
REQ-026 DONE: done=1, acc held; start=1 -> ISSUE with pc<=0, acc retained (runs accumulate); otherwise stay.
REQ-027 In IDLE and DONE, alu_a=0 and alu_fun=000.
REQ-028 load is accepted only in IDLE or DONE; writes mem[load_addr] on that edge; ignored in ISSUE/CAPTURE.
REQ-029 load and start in the same IDLE/DONE cycle: both accepted; the write lands on that edge, so entry 0 reads the new value if load_addr=0.
REQ-030 start during ISSUE/CAPTURE is ignored; no restart, no pc change.
REQ-031 acc is 8 bits; alu_result is stored unmodified; alu_b uses only acc[3:0] (upper bits are display-only).

Reset
REQ-032 reset=1 on a posedge: state<=IDLE, pc<=0, acc<=0, all memory entries <={000,0,0}; busy=0, done=0, alu_a=0, alu_fun=000 in the next cycle.
REQ-033 reset has priority over start and load in the same cycle; reset mid-run aborts the program with no further acc update.

Verification
REQ-034 Assert reset for 1 cycle -> acc=0x00, pc=0, busy=0, done=0, alu_fun=000.
REQ-035 Load e0={001,3,0}, e1={111,2,1}; pulse start -> after 2 edges acc=0x03, after 4 edges acc=0x06, done=1, pc=1, busy high exactly 4 cycles.
REQ-036 Load all 8 entries {000,5,0}; start -> acc=0x06 after each capture, done after 16 cycles, pc=7, no wrap to 0.
REQ-037 With acc=0x06 in DONE, load e0={101,1,1}; start -> alu_b=6, acc=0x0C after 2 edges; then start again with e0={110,2,1} -> acc=0x03.
REQ-038 During a run, pulse start and load(addr 0) -> pc sequence and acc identical to an undisturbed run; mem[0] unchanged.
REQ-039 Assert reset in CAPTURE of entry 1 -> next cycle state IDLE, acc=0x00, done=0; a later start with no loads executes {000,0,0} x8 -> acc=0x01.
